// File: rtl/gf180_ram_64x8_ctrl.sv
`default_nettype none
// gf180_ram_64x8_ctrl: valid/ready front-end for a 64x8 GF180 SRAM with a 2-deep read response FIFO.
// Define RAM_INIT_EN to add a power-up sweep writing INIT_VALUE to every word.
module gf180_ram_64x8_ctrl #(
  parameter logic [7:0] INIT_VALUE = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic [7:0] req_wmask,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       init_done,
  output logic       ram_cen,
  output logic       ram_gwen,
  output logic [7:0] ram_wen,
  output logic [5:0] ram_a,
  output logic [7:0] ram_d,
  input  logic [7:0] ram_q
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       run;
  logic       credit;
  logic       req_fire;
  logic       rd_fire;
  logic       push;
  logic       pop;
  logic       inflight;
  logic [7:0] fifo_mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;

`ifdef RAM_INIT_EN
  localparam state_t RESET_STATE = ST_INIT;
  logic       sweeping;
  logic [5:0] sweep_cnt;

  assign sweeping = (state == ST_INIT) && !RST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sweep_cnt <= '0;
    end else if (state == ST_INIT) begin
      sweep_cnt <= sweep_cnt + 6'd1;
    end
  end
`else
  localparam state_t RESET_STATE = ST_RUN;
  logic unused_init_value;
  assign unused_init_value = ^INIT_VALUE;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RESET_STATE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
`ifdef RAM_INIT_EN
    if ((state == ST_INIT) && (sweep_cnt == 6'd63)) begin
      state_next = ST_RUN;
    end
`endif
  end

  assign init_done = (state == ST_RUN);
  assign run       = (state == ST_RUN) && !RST;

  // Read credit counts the read still in the SRAM pipe; a pop this cycle is not credit.
  assign credit    = inflight ? (count == 2'd0) : (count != 2'd2);
  assign req_ready = run && (req_we || credit);
  assign req_fire  = req_valid && req_ready;
  assign rd_fire   = req_fire && !req_we;
  assign push      = inflight;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    ram_cen  = 1'b1;
    ram_gwen = 1'b1;
    ram_wen  = 8'hFF;
    ram_a    = '0;
    ram_d    = '0;
`ifdef RAM_INIT_EN
    if (sweeping) begin
      ram_cen  = 1'b0;
      ram_gwen = 1'b0;
      ram_wen  = 8'h00;
      ram_a    = sweep_cnt;
      ram_d    = INIT_VALUE;
    end else
`endif
    if (req_fire) begin
      ram_cen  = 1'b0;
      ram_gwen = !req_we;
      ram_wen  = req_we ? ~req_wmask : 8'hFF;
      ram_a    = req_addr;
      ram_d    = req_wdata;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inflight    <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      fifo_mem[0] <= 8'h00;
      fifo_mem[1] <= 8'h00;
    end else begin
      inflight <= rd_fire;
      if (push) begin
        fifo_mem[wr_ptr] <= ram_q;
        wr_ptr           <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rsp_valid = (count != 2'd0);
  assign rsp_data  = fifo_mem[rd_ptr];

endmodule
`default_nettype wire

// File: doc/gf180_ram_64x8_ctrl.md
GF180_RAM_64X8_CTRL -- requirements
Module: gf180_ram_64x8_ctrl

Interface
REQ-001 Parameter INIT_VALUE, default 8'h00: data written to every word by the init sweep.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  request accepted when req_valid & req_ready at a rising edge.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  6  word address.
REQ-008 req_wdata  input  8  write data.
REQ-009 req_wmask  input  8  active-high per-bit write enable.
REQ-010 rsp_valid  output  1  read data available.
REQ-011 rsp_ready  input  1  consumer takes rsp_data when rsp_valid & rsp_ready.
REQ-012 rsp_data  output  8  read data.
REQ-013 init_done  output  1  high once the controller accepts requests.
REQ-014 ram_cen, ram_gwen  output  1 each  active-low chip enable and global write enable to the 64x8 SRAM wrapper.
REQ-015 ram_wen  output  8  active-low bit write enables to the SRAM.
REQ-016 ram_a  output  6; ram_d  output  8; ram_q  input  8  SRAM address, write data, read data.

Function
REQ-017 The block SHALL have two states, INIT and RUN; req_ready SHALL be 0 in INIT.
REQ-018 In RUN, an accepted request SHALL drive the SRAM combinationally in the same cycle: ram_cen=0, ram_gwen=~req_we, ram_wen=~req_wmask for writes or 8'hFF for reads, ram_a=req_addr, ram_d=req_wdata.
REQ-019 When no request is accepted and the block is not sweeping, ram_cen SHALL be 1, ram_gwen 1, and ram_wen 8'hFF.
REQ-020 Writes SHALL produce no response, and a write with req_wmask=0 SHALL be accepted and leave memory unchanged.
REQ-021 A read accepted at edge N SHALL set an in-flight flag; ram_q SHALL be captured at edge N+1 into a 2-entry response FIFO; rsp_valid SHALL rise in the cycle after edge N+1 (latency 2 cycles).
REQ-022 In RUN, req_ready SHALL be 1 for writes unconditionally.
REQ-023 In RUN, req_ready SHALL be 1 for reads only when (in-flight + FIFO occupancy) < 2; a same-cycle pop does not grant credit.
REQ-024 Responses SHALL return in request order; push and pop in the same cycle SHALL both occur with occupancy unchanged.
REQ-025 rsp_data SHALL be FIFO-head data and SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-026 Back-to-back accepted reads SHALL be issued one per cycle while credit allows.

Reset
REQ-027 While RST=1: rsp_valid=0, rsp_data=0, FIFO and in-flight flag cleared, ram_cen=1, ram_gwen=1, ram_wen=8'hFF, ram_a=0, ram_d=0, req_ready=0.
REQ-028 Reset asserted mid-read SHALL discard the in-flight read; no response SHALL appear after release.
REQ-029 State after reset SHALL be INIT if RAM_INIT_EN is defined, otherwise RUN with init_done=1.

Configuration
REQ-030 With macro RAM_INIT_EN defined, INIT SHALL sweep addresses 0..63, one per cycle (ram_cen=0, ram_gwen=0, ram_wen=0, ram_d=INIT_VALUE), then enter RUN with init_done=1 at the 65th cycle after reset release.
REQ-031 Without RAM_INIT_EN, no sweep logic SHALL exist, and req_ready SHALL be valid in the first cycle after reset release.

Verification
REQ-032 Write 0xA5 to addr 3 with mask 0xFF, then read addr 3 -> rsp_valid 2 cycles after the read is accepted, rsp_data=0xA5.
REQ-033 Write 0xFF to addr 7 with mask 0x0F over 0x00 -> read addr 7 returns 0x0F.
REQ-034 Three back-to-back reads with rsp_ready=0 -> only 2 accepted, req_ready=0 until a pop, data in order.
REQ-035 With RAM_INIT_EN and INIT_VALUE=0x3C -> init_done rises 64 cycles after reset release; reads of addr 0 and 63 return 0x3C.
REQ-036 Assert RST the cycle after a read is accepted -> no rsp_valid after release, all RAM outputs at reset values.
